// File: rtl/ctr_uart_pkg.sv
// Shared state encoding and frame constants for the counter UART transmitter.
package ctr_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Bit-period divider must leave at least one non-boundary cycle and fit 16 bits.
    function automatic bit clk_div_legal(input int div);
        return (div >= 2) && (div <= 65535);
    endfunction

endpackage

// File: rtl/ctr_uart_tx_if.sv
// Byte handshake between the counter (master) and the UART transmitter (slave).
interface ctr_uart_tx_if;
    import ctr_uart_pkg::*;

    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/ctr_uart_tx_baud_div.sv
// Bit-period divider: free-running 0..CLK_DIV-1 counter with a restart that pins it at zero.
module uart_baud_div #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // High during the last cycle of each bit period.
    assign tick = (count == LAST);

endmodule

// File: rtl/ctr_uart_tx.sv
// 8N1 UART transmitter for the blinky counter output: one-byte holding register
// in front of a start/data/stop shift FSM, LSB first, idle-high line.
module ctr_uart_tx
    import ctr_uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    ctr_uart_tx_if.slave up,
    output logic         tx,
    output logic         busy
);

    if (!clk_div_legal(CLK_DIV)) begin : g_bad_clk_div
        $error("ctr_uart_tx: CLK_DIV must be in 2..65535");
    end

    uart_state_t               state;
    logic [UART_DATA_BITS-1:0] hold_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      hold_full;
    logic [2:0]                bit_idx;
    logic                      tick;
    logic                      restart;
    logic                      accept;
    logic                      load;
    logic                      hold_nxt;

    assign accept   = up.in_valid && up.in_ready;
    // The shifter takes the held byte from IDLE or at the very end of a stop bit.
    assign load     = hold_full && ((state == IDLE) || ((state == STOP) && tick));
    assign hold_nxt = accept || (hold_full && !load);
    // Keeping the divider at zero while idle makes the start bit a full period.
    assign restart  = (state == IDLE);

    uart_baud_div #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_q <= up.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            shift_q <= hold_q;
        end else if ((state == DATA) && tick) begin
            shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold_full   <= 1'b0;
            up.in_ready <= 1'b1;
            busy        <= 1'b0;
            tx          <= 1'b1;
            bit_idx     <= '0;
        end else begin
            hold_full   <= hold_nxt;
            up.in_ready <= !hold_nxt;
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= hold_nxt;
                    end
                end
                START: begin
                    busy <= 1'b1;
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shift_q[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    busy <= 1'b1;
                    if (tick) begin
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx      <= shift_q[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (load) begin
                            state <= START;
                            tx    <= 1'b0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= hold_nxt;
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= hold_nxt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_uart_tx.sv
// Scoreboard bench for ctr_uart_tx: timing model of tx/in_ready/busy plus a line decoder
// that pops expected frames as they appear on tx.
module tb_ctr_uart_tx;
    import ctr_uart_pkg::*;

    localparam int D     = 4;
    localparam int FRAME = UART_FRAME_BITS * D;

    typedef struct {
        int         acc;
        int         start;
        logic [7:0] data;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    ctr_uart_tx_if ifc ();

    ctr_uart_tx #(
        .CLK_DIV (D)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .up   (ifc),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_start = -1000000;
    frame_t     exp_q[$];
    frame_t     nf;
    int         exp_rd = 0;
    int         mdl_rd = 0;
    logic [7:0] dec_log[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each accepted byte starts one cycle later, or right after the previous frame.
    always @(posedge clk) begin
        if (rst) begin
            last_start = -1000000;
        end else if (ifc.in_valid && ifc.in_ready) begin
            nf.acc   = cyc;
            nf.data  = ifc.in_data;
            nf.start = (cyc + 2 > last_start + FRAME) ? cyc + 2 : last_start + FRAME;
            last_start = nf.start;
            exp_q.push_back(nf);
        end
    end

    // Cycle checker: line level, in_ready and busy against the model.
    logic       m_hold, m_busy, m_tx;
    logic [9:0] m_bits;
    always @(negedge clk) begin
        if (rst) begin
            mdl_rd = exp_q.size();
            chk("reset_outputs", {29'd0, tx, ifc.in_ready, busy}, 32'b110);
        end else begin
            m_hold = 1'b0;
            m_busy = 1'b0;
            m_tx   = 1'b1;
            for (int i = mdl_rd; i < exp_q.size(); i++) begin
                if (cyc >= exp_q[i].acc + 1 && cyc < exp_q[i].start) m_hold = 1'b1;
                if (cyc >= exp_q[i].acc + 1 && cyc < exp_q[i].start + FRAME) m_busy = 1'b1;
                if (cyc >= exp_q[i].start && cyc < exp_q[i].start + FRAME) begin
                    m_bits = {1'b1, exp_q[i].data, 1'b0};
                    m_tx   = m_bits[(cyc - exp_q[i].start) / D];
                end
            end
            chk("line_state", {29'd0, tx, ifc.in_ready, busy}, {29'd0, m_tx, !m_hold, m_busy});
            while (mdl_rd < exp_q.size() && cyc >= exp_q[mdl_rd].start + FRAME - 1) mdl_rd++;
        end
    end

    // Monitor: UART decoder sampling mid-bit, popping the scoreboard at each frame end.
    bit         dec_on = 1'b0;
    int         dec_cnt = 0;
    int         dec_start = 0;
    logic [9:0] dec_bits;
    always @(negedge clk) begin
        if (rst) begin
            dec_on = 1'b0;
            exp_rd = exp_q.size();
        end else if (dec_on) begin
            if (dec_cnt % D == D / 2) dec_bits[dec_cnt / D] = tx;
            dec_cnt++;
            if (dec_cnt == FRAME) begin
                dec_on = 1'b0;
                dec_log.push_back(dec_bits[8:1]);
                if (exp_rd >= exp_q.size()) begin
                    chk("frame_unexpected", {22'd0, dec_bits}, 32'hFFFF_FFFF);
                end else begin
                    chk("frame_bits", {22'd0, dec_bits}, {22'd0, 1'b1, exp_q[exp_rd].data, 1'b0});
                    chk("frame_start", dec_start, exp_q[exp_rd].start);
                    exp_rd++;
                end
            end
        end else if (tx == 1'b0) begin
            dec_on    = 1'b1;
            dec_cnt   = 1;
            dec_start = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit keep);
        int guard = 0;
        ifc.in_data  = b;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && guard < 4 * FRAME) begin
            step(1);
            guard++;
        end
        chk("send_ready", {31'd0, ifc.in_ready}, 32'd1);
        step(1);
        if (!keep) ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || exp_rd < exp_q.size()) && guard < 300 * FRAME) begin
            step(1);
            guard++;
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_pending", exp_q.size() - exp_rd, 0);
    endtask

    task automatic wait_tx_low();
        int guard = 0;
        while (tx !== 1'b0 && guard < 4 * FRAME) begin
            step(1);
            guard++;
        end
        chk("start_seen", {31'd0, tx}, 32'd0);
    endtask

    task automatic async_reset(input string name);
        #1;
        rst = 1'b1;
        #1;
        chk(name, {29'd0, tx, ifc.in_ready, busy}, 32'b110);
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        int base;
        ifc.in_data  = 8'h00;
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        step(5);
        rst = 1'b0;
        step(3);

        send(8'hA5, 1'b0);
        wait_idle();

        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();

        for (int i = 0; i < 3; i++) send(8'($urandom), i < 2);
        wait_idle();

        send(8'h5A, 1'b0);
        wait_tx_low();
        step(4 * D + 1);
        async_reset("rst_data_bit3");
        send(8'h3C, 1'b0);
        wait_idle();

        send(8'($urandom), 1'b0);
        wait_tx_low();
        step(9 * D + 1);
        async_reset("rst_stop");

        send(8'($urandom), 1'b0);
        wait_tx_low();
        step(1);
        async_reset("rst_start_bit");
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            send(8'($urandom), keep);
            if (!keep) step($urandom_range(0, FRAME + 2));
        end
        ifc.in_valid = 1'b0;
        wait_idle();

        base = dec_log.size();
        for (int v = 0; v <= 256; v++) send(8'(v), v < 256);
        wait_idle();
        chk("e2e_count", dec_log.size() - base, 257);
        for (int i = 0; i < 257 && base + i < dec_log.size(); i++)
            chk("e2e_value", {24'd0, dec_log[base + i]}, i & 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
